// File: rtl/epmp_mem_arbiter.sv
// EPMP memory arbiter: shares the external synchronous memory port between
// the CPU control unit and the debug/monitor host port. Each access runs
// IDLE -> ACCESS -> (WAIT for reads) -> ACK, one access outstanding at a time.
// Optional build macro EPMP_ARB_HOST_LOCK_EN adds host_lock_i, which masks the
// CPU request in IDLE so the host gets exclusive use of the memory.
module epmp_mem_arbiter #(
    parameter int unsigned AW          = 8,
    parameter int unsigned DW          = 8,
    parameter int unsigned RD_LATENCY  = 1,
    parameter int unsigned ROUND_ROBIN = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
`ifdef EPMP_ARB_HOST_LOCK_EN
    input  logic          host_lock_i,
`endif
    input  logic          cpu_req_i,
    input  logic          cpu_we_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic [DW-1:0] cpu_wdata_i,
    output logic [DW-1:0] cpu_rdata_o,
    output logic          cpu_ack_o,
    input  logic          host_req_i,
    input  logic          host_we_i,
    input  logic [AW-1:0] host_addr_i,
    input  logic [DW-1:0] host_wdata_i,
    output logic [DW-1:0] host_rdata_o,
    output logic          host_ack_o,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    output logic          grant_host_o,
    output logic          busy_o
);

    localparam int unsigned CW = 2;

    // Read latency must fit the 2-bit wait counter.
    if (RD_LATENCY < 1 || RD_LATENCY > 3) begin : g_bad_rd_latency
        $error("epmp_mem_arbiter: RD_LATENCY must be in 1..3");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_ACK    = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          grant_host_q, grant_host_d;
    logic          last_host_q, last_host_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] host_rdata_q, host_rdata_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic          host_ack_q, host_ack_d;
    logic          busy_q, busy_d;
    logic          cpu_req_eff;
    logic          pick_host;

    // CPU request as seen by arbitration (masked while the host holds the lock).
`ifdef EPMP_ARB_HOST_LOCK_EN
    assign cpu_req_eff = cpu_req_i & ~host_lock_i;
`else
    assign cpu_req_eff = cpu_req_i;
`endif

    // State register and all registered outputs; reset aborts any access.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            grant_host_q <= 1'b0;
            last_host_q  <= 1'b1;
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
            cpu_ack_q    <= 1'b0;
            host_ack_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            grant_host_q <= grant_host_d;
            last_host_q  <= last_host_d;
            cpu_rdata_q  <= cpu_rdata_d;
            host_rdata_q <= host_rdata_d;
            cpu_ack_q    <= cpu_ack_d;
            host_ack_q   <= host_ack_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state logic; registered outputs are computed for the state being entered.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        grant_host_d = grant_host_q;
        last_host_d  = last_host_q;
        cpu_rdata_d  = cpu_rdata_q;
        host_rdata_d = host_rdata_q;
        cpu_ack_d    = 1'b0;
        host_ack_d   = 1'b0;
        pick_host    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cpu_req_eff && host_req_i) begin
                    pick_host = (ROUND_ROBIN != 0) ? ~last_host_q : 1'b0;
                end else begin
                    pick_host = host_req_i;
                end
                if (cpu_req_eff || host_req_i) begin
                    grant_host_d = pick_host;
                    mem_en_d     = 1'b1;
                    mem_we_d     = pick_host ? host_we_i    : cpu_we_i;
                    mem_addr_d   = pick_host ? host_addr_i  : cpu_addr_i;
                    mem_wdata_d  = pick_host ? host_wdata_i : cpu_wdata_i;
                    state_d      = S_ACCESS;
                end
            end
            S_ACCESS: begin
                // mem_we_q still holds the latched direction during this cycle.
                if (mem_we_q) begin
                    cpu_ack_d  = ~grant_host_q;
                    host_ack_d = grant_host_q;
                    state_d    = S_ACK;
                end else begin
                    cnt_d   = CW'(RD_LATENCY - 1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    if (grant_host_q) begin
                        host_rdata_d = mem_rdata_i;
                    end else begin
                        cpu_rdata_d  = mem_rdata_i;
                    end
                    cpu_ack_d  = ~grant_host_q;
                    host_ack_d = grant_host_q;
                    state_d    = S_ACK;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_ACK: begin
                last_host_d = grant_host_q;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign cpu_rdata_o  = cpu_rdata_q;
    assign cpu_ack_o    = cpu_ack_q;
    assign host_rdata_o = host_rdata_q;
    assign host_ack_o   = host_ack_q;
    assign mem_en_o     = mem_en_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign grant_host_o = grant_host_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_epmp_mem_arbiter.sv
// Directed bench for epmp_mem_arbiter. Three instances share one clock/reset:
//   0: RD_LATENCY=1, round robin   1: RD_LATENCY=1, CPU priority
//   2: RD_LATENCY=3, round robin
// The memory model returns addr ^ 8'h99 one cycle after a read enable.
module tb_epmp_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_req    [3];
    logic       cpu_we     [3];
    logic [7:0] cpu_addr   [3];
    logic [7:0] cpu_wdata  [3];
    logic [7:0] cpu_rdata  [3];
    logic       cpu_ack    [3];
    logic       host_req   [3];
    logic       host_we    [3];
    logic [7:0] host_addr  [3];
    logic [7:0] host_wdata [3];
    logic [7:0] host_rdata [3];
    logic       host_ack   [3];
    logic       mem_en     [3];
    logic       mem_we     [3];
    logic [7:0] mem_addr   [3];
    logic [7:0] mem_wdata  [3];
    logic [7:0] mem_rdata  [3];
    logic       grant_host [3];
    logic       busy       [3];
`ifdef EPMP_ARB_HOST_LOCK_EN
    logic       host_lock  [3];
`endif

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    epmp_mem_arbiter #(.AW(8), .DW(8), .RD_LATENCY(1), .ROUND_ROBIN(1)) u_rr (
        .clk_i(clk), .rst_i(rst),
`ifdef EPMP_ARB_HOST_LOCK_EN
        .host_lock_i(host_lock[0]),
`endif
        .cpu_req_i(cpu_req[0]), .cpu_we_i(cpu_we[0]), .cpu_addr_i(cpu_addr[0]),
        .cpu_wdata_i(cpu_wdata[0]), .cpu_rdata_o(cpu_rdata[0]), .cpu_ack_o(cpu_ack[0]),
        .host_req_i(host_req[0]), .host_we_i(host_we[0]), .host_addr_i(host_addr[0]),
        .host_wdata_i(host_wdata[0]), .host_rdata_o(host_rdata[0]), .host_ack_o(host_ack[0]),
        .mem_en_o(mem_en[0]), .mem_we_o(mem_we[0]), .mem_addr_o(mem_addr[0]),
        .mem_wdata_o(mem_wdata[0]), .mem_rdata_i(mem_rdata[0]),
        .grant_host_o(grant_host[0]), .busy_o(busy[0])
    );

    epmp_mem_arbiter #(.AW(8), .DW(8), .RD_LATENCY(1), .ROUND_ROBIN(0)) u_fp (
        .clk_i(clk), .rst_i(rst),
`ifdef EPMP_ARB_HOST_LOCK_EN
        .host_lock_i(host_lock[1]),
`endif
        .cpu_req_i(cpu_req[1]), .cpu_we_i(cpu_we[1]), .cpu_addr_i(cpu_addr[1]),
        .cpu_wdata_i(cpu_wdata[1]), .cpu_rdata_o(cpu_rdata[1]), .cpu_ack_o(cpu_ack[1]),
        .host_req_i(host_req[1]), .host_we_i(host_we[1]), .host_addr_i(host_addr[1]),
        .host_wdata_i(host_wdata[1]), .host_rdata_o(host_rdata[1]), .host_ack_o(host_ack[1]),
        .mem_en_o(mem_en[1]), .mem_we_o(mem_we[1]), .mem_addr_o(mem_addr[1]),
        .mem_wdata_o(mem_wdata[1]), .mem_rdata_i(mem_rdata[1]),
        .grant_host_o(grant_host[1]), .busy_o(busy[1])
    );

    epmp_mem_arbiter #(.AW(8), .DW(8), .RD_LATENCY(3), .ROUND_ROBIN(1)) u_l3 (
        .clk_i(clk), .rst_i(rst),
`ifdef EPMP_ARB_HOST_LOCK_EN
        .host_lock_i(host_lock[2]),
`endif
        .cpu_req_i(cpu_req[2]), .cpu_we_i(cpu_we[2]), .cpu_addr_i(cpu_addr[2]),
        .cpu_wdata_i(cpu_wdata[2]), .cpu_rdata_o(cpu_rdata[2]), .cpu_ack_o(cpu_ack[2]),
        .host_req_i(host_req[2]), .host_we_i(host_we[2]), .host_addr_i(host_addr[2]),
        .host_wdata_i(host_wdata[2]), .host_rdata_o(host_rdata[2]), .host_ack_o(host_ack[2]),
        .mem_en_o(mem_en[2]), .mem_we_o(mem_we[2]), .mem_addr_o(mem_addr[2]),
        .mem_wdata_o(mem_wdata[2]), .mem_rdata_i(mem_rdata[2]),
        .grant_host_o(grant_host[2]), .busy_o(busy[2])
    );

    // Synchronous memory: read data appears the cycle after the enable.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (mem_en[k] && !mem_we[k]) mem_rdata[k] <= mem_addr[k] ^ 8'h99;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] all_outs(input int k);
        return 64'({mem_en[k], mem_we[k], cpu_ack[k], host_ack[k], grant_host[k], busy[k],
                    mem_addr[k], mem_wdata[k], cpu_rdata[k], host_rdata[k]});
    endfunction

    int ev_cyc [8];
    int ev_who [8];
    int nev;
    int cnt_c;
    int cnt_h;

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cpu_req[k] = 1'b0;  cpu_we[k] = 1'b0;  cpu_addr[k] = '0;  cpu_wdata[k] = '0;
            host_req[k] = 1'b0; host_we[k] = 1'b0; host_addr[k] = '0; host_wdata[k] = '0;
`ifdef EPMP_ARB_HOST_LOCK_EN
            host_lock[k] = 1'b0;
`endif
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) chk($sformatf("reset_outs%0d", k), all_outs(k), 64'd0);
        rst = 1'b0;
        tick();
        tick();

        // CPU read of 0x3C on instance 0.
        cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = 8'h3C;
        tick();
        chk("rd_c1_en",   64'(mem_en[0]),   64'd1);
        chk("rd_c1_we",   64'(mem_we[0]),   64'd0);
        chk("rd_c1_addr", 64'(mem_addr[0]), 64'h3C);
        chk("rd_c1_busy", 64'(busy[0]),     64'd1);
        tick();
        chk("rd_c2_en",   64'(mem_en[0]),   64'd0);
        chk("rd_c2_ack",  64'(cpu_ack[0]),  64'd0);
        tick();
        chk("rd_c3_ack",   64'(cpu_ack[0]),    64'd1);
        chk("rd_c3_data",  64'(cpu_rdata[0]),  64'hA5);
        chk("rd_c3_hack",  64'(host_ack[0]),   64'd0);
        chk("rd_c3_grant", 64'(grant_host[0]), 64'd0);
        cpu_req[0] = 1'b0;
        tick();
        chk("rd_c4_ack",  64'(cpu_ack[0]),   64'd0);
        chk("rd_c4_busy", 64'(busy[0]),      64'd0);
        chk("rd_c4_hold", 64'(cpu_rdata[0]), 64'hA5);

        // Host write of 0x5A to 0x10 on instance 0.
        host_req[0] = 1'b1; host_we[0] = 1'b1; host_addr[0] = 8'h10; host_wdata[0] = 8'h5A;
        tick();
        chk("wr_c1_en",    64'(mem_en[0]),     64'd1);
        chk("wr_c1_we",    64'(mem_we[0]),     64'd1);
        chk("wr_c1_addr",  64'(mem_addr[0]),   64'h10);
        chk("wr_c1_wdata", 64'(mem_wdata[0]),  64'h5A);
        chk("wr_c1_grant", 64'(grant_host[0]), 64'd1);
        tick();
        chk("wr_c2_hack",  64'(host_ack[0]),   64'd1);
        chk("wr_c2_cack",  64'(cpu_ack[0]),    64'd0);
        chk("wr_c2_crd",   64'(cpu_rdata[0]),  64'hA5);
        chk("wr_c2_hrd",   64'(host_rdata[0]), 64'h00);
        host_req[0] = 1'b0; host_we[0] = 1'b0;
        tick();
        chk("wr_c3_busy", 64'(busy[0]), 64'd0);

        // Contention, both reads held: round robin (inst 0) vs CPU priority (inst 1).
        for (int k = 0; k < 2; k++) begin
            cpu_req[k] = 1'b1;  cpu_we[k] = 1'b0;  cpu_addr[k] = 8'h01;
            host_req[k] = 1'b1; host_we[k] = 1'b0; host_addr[k] = 8'h02;
        end
        nev = 0; cnt_c = 0; cnt_h = 0;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if ((cpu_ack[0] || host_ack[0]) && nev < 8) begin
                ev_cyc[nev] = c;
                ev_who[nev] = host_ack[0] ? 1 : 0;
                nev++;
            end
            if (cpu_ack[1])  cnt_c++;
            if (host_ack[1]) cnt_h++;
        end
        for (int k = 0; k < 2; k++) begin
            cpu_req[k] = 1'b0; host_req[k] = 1'b0;
        end
        chk("rr_nev", 64'(nev), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr_cyc%0d", i), 64'(ev_cyc[i]), 64'(3 + 4 * i));
            chk($sformatf("rr_who%0d", i), 64'(ev_who[i]), 64'(i % 2));
        end
        chk("rr_crd", 64'(cpu_rdata[0]),  64'h98);
        chk("rr_hrd", 64'(host_rdata[0]), 64'h9B);
        chk("fp_cpu_acks",  64'(cnt_c), 64'd4);
        chk("fp_host_acks", 64'(cnt_h), 64'd0);
        tick();
        tick();
        chk("rr_idle", 64'(busy[0]), 64'd0);
        chk("fp_idle", 64'(busy[1]), 64'd0);

        // RD_LATENCY=3 host read of 0x77 on instance 2.
        host_req[2] = 1'b1; host_we[2] = 1'b0; host_addr[2] = 8'h77;
        for (int c = 1; c <= 6; c++) begin
            tick();
            chk($sformatf("l3_busy_c%0d", c), 64'(busy[2]),     64'(c <= 5));
            chk($sformatf("l3_hack_c%0d", c), 64'(host_ack[2]), 64'(c == 5));
            if (c == 5) begin
                chk("l3_hrd", 64'(host_rdata[2]), 64'hEE);
                host_req[2] = 1'b0;
            end
        end

        // Reset during WAIT of a CPU read, with a host read pending (instance 0).
        cpu_req[0] = 1'b1;  cpu_we[0] = 1'b0;  cpu_addr[0] = 8'h20;
        host_req[0] = 1'b1; host_we[0] = 1'b0; host_addr[0] = 8'h30;
        tick();
        chk("ab_c1_grant", 64'(grant_host[0]), 64'd0);
        chk("ab_c1_addr",  64'(mem_addr[0]),   64'h20);
        tick();
        chk("ab_c2_busy", 64'(busy[0]), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("ab_async_clear", all_outs(0), 64'd0);
        cpu_req[0] = 1'b0;
        tick();
        tick();
        chk("ab_held_clear", all_outs(0), 64'd0);
        #2;
        rst = 1'b0;
        tick();
        chk("ab_host_en",    64'(mem_en[0]),     64'd1);
        chk("ab_host_grant", 64'(grant_host[0]), 64'd1);
        chk("ab_host_addr",  64'(mem_addr[0]),   64'h30);
        tick();
        chk("ab_no_cack", 64'(cpu_ack[0]), 64'd0);
        tick();
        chk("ab_hack",    64'(host_ack[0]),   64'd1);
        chk("ab_hrd",     64'(host_rdata[0]), 64'hA9);
        chk("ab_crd",     64'(cpu_rdata[0]),  64'h00);
        host_req[0] = 1'b0;
        tick();
        chk("ab_idle", 64'(busy[0]), 64'd0);

`ifdef EPMP_ARB_HOST_LOCK_EN
        // Host lock: only host accesses while locked, CPU next after release.
        host_lock[0] = 1'b1;
        cpu_req[0] = 1'b1;  cpu_we[0] = 1'b0;  cpu_addr[0] = 8'h44;
        host_req[0] = 1'b1; host_we[0] = 1'b0; host_addr[0] = 8'h55;
        cnt_c = 0; cnt_h = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (cpu_ack[0])  cnt_c++;
            if (host_ack[0]) cnt_h++;
        end
        chk("lk_cpu_acks",  64'(cnt_c), 64'd0);
        chk("lk_host_acks", 64'(cnt_h), 64'd3);
        host_lock[0] = 1'b0;
        tick();
        chk("lk_rel_en",    64'(mem_en[0]),     64'd1);
        chk("lk_rel_grant", 64'(grant_host[0]), 64'd0);
        chk("lk_rel_addr",  64'(mem_addr[0]),   64'h44);
        cpu_req[0] = 1'b0; host_req[0] = 1'b0;
        repeat (4) tick();
        chk("lk_idle", 64'(busy[0]), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/epmp_mem_arbiter.md
Name: epmp_mem_arbiter

Overview:
- Shares the single external memory port of the EPMP between the CPU control unit's Read/Write cycles and a debug/monitor host port used for memory inspection and loading.
- Sequences each access through a fixed-latency synchronous memory: address phase, read-wait, then an acknowledge pulse to the winning requester.
- Sits between the CU/MDR/MAR memory interface and the board RAM.

Parameters:
- AW, 8, address width in bits.
- DW, 8, data width in bits.
- RD_LATENCY, 1, memory read latency in cycles (legal 1..3).
- ROUND_ROBIN, 1, 1 = alternate grant on contention; 0 = CPU fixed priority.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU access request (level, held until cpu_ack).
- cpu_we  in  1  1 = write, 0 = read; valid while cpu_req is high.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_rdata  out  DW  CPU read data; valid when cpu_ack is high, held until the next CPU read completes.
- cpu_ack  out  1  one-cycle completion pulse to the CPU.
- host_req  in  1  host access request (level, held until host_ack).
- host_we  in  1  host write enable.
- host_addr  in  AW  host address.
- host_wdata  in  DW  host write data.
- host_rdata  out  DW  host read data; same rules as cpu_rdata.
- host_ack  out  1  one-cycle completion pulse to the host.
- mem_en  out  1  memory enable, one cycle per access.
- mem_we  out  1  memory write strobe, qualifies mem_en.
- mem_addr  out  AW  memory address, registered.
- mem_wdata  out  DW  memory write data, registered.
- mem_rdata  in  DW  memory read data.
- grant_host  out  1  1 while the current or last access belongs to the host.
- busy  out  1  1 in any state other than IDLE.

Behaviour:
- All outputs are registered.
- Reset value of every output is 0. This includes cpu_rdata, host_rdata and grant_host. The round-robin history register resets to "host last served", so the CPU wins the first contention.
- FSM states:
  - IDLE: busy = 0. Samples both requests.
    - No request: stay in IDLE.
    - One request: grant it.
    - Both requests, ROUND_ROBIN = 1: grant the requester not served last.
    - Both requests, ROUND_ROBIN = 0: grant the CPU.
    - On any grant: latch we/addr/wdata into the mem_* registers, set grant_host, go to ACCESS.
  - ACCESS: mem_en = 1 and mem_we = latched we, for exactly one cycle. Write goes to ACK. Read goes to WAIT with the wait counter loaded to RD_LATENCY-1.
  - WAIT: the counter decrements each cycle. When the counter is 0, capture mem_rdata into the granted requester's rdata register and go to ACK.
  - ACK: pulse cpu_ack or host_ack for one cycle, update the round-robin history, go to IDLE.
- Latency, counted from the IDLE cycle where the request is sampled (cycle 0):
  - Write: ack in cycle 2.
  - Read: ack in cycle 2 + RD_LATENCY.
- Handshake:
  - A requester must hold req and its qualifiers stable until it sees ack.
  - It drops req at the clock edge where it samples ack high. The IDLE cycle that follows therefore sees no request from it.
  - A req still high in that IDLE cycle is a new access.
- Only one access is outstanding at a time. The non-granted requester waits with no loss of its request.
- The non-granted rdata register is never disturbed.
- Changes to req, we, addr or wdata after the grant are ignored until ACK.
- Asynchronous Reset mid-access: immediately return to IDLE and clear all outputs. No ack is issued for the aborted access, and no further mem_en is driven.
- RD_LATENCY outside 1..3 is a configuration error, flagged by a simulation-only check at time 0.

Optional Feature:
- Macro: EPMP_ARB_HOST_LOCK_EN.
- When defined:
  - Adds input host_lock (1 bit).
  - While host_lock = 1, cpu_req is ignored in IDLE, so the host has exclusive use and the CPU stalls. This is used for debug freeze and memory download.
  - A CPU access already past IDLE completes normally.
  - Deasserting host_lock restores normal arbitration from the next IDLE cycle.
- When undefined: no host_lock port; arbitration exactly as described above.

Test Plan:
- CPU read, RD_LATENCY = 1, cpu_addr = 0x3C, memory returns 0xA5 → mem_en high in cycle 1 only; cpu_ack in cycle 3 with cpu_rdata = 0xA5; host_ack stays 0.
- Host write, addr 0x10, data 0x5A → cycle 1 shows mem_en = 1, mem_we = 1, mem_addr = 0x10, mem_wdata = 0x5A; host_ack in cycle 2; grant_host = 1.
- Both requests held continuously (reads), ROUND_ROBIN = 1 → grants alternate CPU, host, CPU, host; each ack is 4 cycles apart. With ROUND_ROBIN = 0 → the CPU is served every time and host_ack never fires while cpu_req is held.
- RD_LATENCY = 3 host read of 0x77 → ack in cycle 5; busy is high in cycles 1–5.
- Reset asserted during WAIT of a CPU read → all outputs 0 asynchronously; no cpu_ack. After release, a pending host_req is served first.
- With EPMP_ARB_HOST_LOCK_EN, host_lock = 1 and both requests held → only host accesses are granted. After host_lock drops, the next IDLE grants the CPU.
